// File: rtl/ctrl_pkg.sv
// Shared decode constants for the ID control stage: opcodes, functs, aluop codes and bundle layout.
// Build option: define MULDIV_EN to decode mult/div/mfhi/mflo and build the busy interlock.
package ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1a;
   localparam logic [5:0] FN_DIVU  = 6'h1b;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_RFN = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;
   localparam logic [2:0] ALU_XOR = 3'b101;
   localparam logic [2:0] ALU_LUI = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam int CTRL_W        = 16;
   localparam int CTRL_SIGNEXT  = 15;
   localparam int CTRL_ALUOP_HI = 14;
   localparam int CTRL_ALUOP_LO = 12;
   localparam int CTRL_ALUSRC   = 11;
   localparam int CTRL_MEMREAD  = 10;
   localparam int CTRL_MEMWRITE = 9;
   localparam int CTRL_MEMTOREG = 8;
   localparam int CTRL_REGWRITE = 7;
   localparam int CTRL_REGDST   = 6;
   localparam int CTRL_BRANCH   = 5;
   localparam int CTRL_BRANCHNE = 4;
   localparam int CTRL_JUMP     = 3;
   localparam int CTRL_JUMPR    = 2;
   localparam int CTRL_LINK     = 1;
   localparam int CTRL_MULDIV   = 0;

   // Field order matches the CTRL_* indices above, MSB first.
   typedef struct packed {
      logic       signext;
      logic [2:0] aluop;
      logic       alusrc;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
      logic       regdst;
      logic       branch;
      logic       branchne;
      logic       jump;
      logic       jumpr;
      logic       link;
      logic       muldiv;
   } ctrl_t;

`ifdef MULDIV_EN
   localparam bit MULDIV_ON = 1'b1;
`else
   localparam bit MULDIV_ON = 1'b0;
`endif

   function automatic logic is_muldiv_fn(input logic [5:0] funct);
      return funct inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
   endfunction

   // Any R-type funct that touches hi/lo: the multi-cycle unit's producers and readers.
   function automatic logic is_hilo_fn(input logic [5:0] funct);
      return is_muldiv_fn(funct) || funct == FN_MFHI || funct == FN_MFLO;
   endfunction

endpackage

// File: rtl/ctrl_dec.sv
// Combinational main decoder: opcode/funct to control bundle, legality and source-register use.
// Build option: MULDIV_EN makes the hi/lo functs legal (via ctrl_pkg::MULDIV_ON).
module ctrl_dec
   import ctrl_pkg::*;
(
   input  logic [5:0]        opcode,
   input  logic [5:0]        funct,
   output logic [CTRL_W-1:0] ctrl,
   output logic              legal,
   output logic              uses_rs,
   output logic              uses_rt
);

   ctrl_t c;

   // NOTE: every output gets a default at the top of the block so no path leaves one unassigned (no latch).
   always_comb begin
      c       = '0;
      legal   = 1'b0;
      uses_rs = 1'b0;
      uses_rt = 1'b0;
      unique case (opcode)
         OP_RTYPE: begin
            legal   = 1'b1;
            uses_rs = 1'b1;
            uses_rt = 1'b1;
            if (funct == FN_JR) begin
               c.jump  = 1'b1;
               c.jumpr = 1'b1;
            end else if (is_hilo_fn(funct) && !MULDIV_ON) begin
               legal   = 1'b0;
               uses_rs = 1'b0;
               uses_rt = 1'b0;
            end else if (is_muldiv_fn(funct)) begin
               c.aluop  = ALU_RFN;
               c.muldiv = 1'b1;
            end else begin
               c.aluop    = ALU_RFN;
               c.regdst   = 1'b1;
               c.regwrite = 1'b1;
            end
         end
         OP_J: begin
            legal  = 1'b1;
            c.jump = 1'b1;
         end
         OP_JAL: begin
            legal      = 1'b1;
            c.jump     = 1'b1;
            c.link     = 1'b1;
            c.regwrite = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            legal      = 1'b1;
            uses_rs    = 1'b1;
            uses_rt    = 1'b1;
            c.aluop    = ALU_SUB;
            c.branch   = 1'b1;
            c.branchne = opcode[0];
         end
         OP_LW: begin
            legal      = 1'b1;
            uses_rs    = 1'b1;
            c.signext  = 1'b1;
            c.alusrc   = 1'b1;
            c.memread  = 1'b1;
            c.memtoreg = 1'b1;
            c.regwrite = 1'b1;
         end
         OP_SW: begin
            legal      = 1'b1;
            uses_rs    = 1'b1;
            uses_rt    = 1'b1;
            c.signext  = 1'b1;
            c.alusrc   = 1'b1;
            c.memwrite = 1'b1;
         end
         default: begin
            // I-type ALU group 001xxx; low three opcode bits select the operation.
            if (opcode[5:3] == 3'b001) begin
               legal      = 1'b1;
               uses_rs    = (opcode != OP_LUI);
               c.alusrc   = 1'b1;
               c.regwrite = 1'b1;
               c.signext  = ~opcode[2];
               unique case (opcode[2:0])
                  3'b000, 3'b001: c.aluop = ALU_ADD;
                  3'b010, 3'b011: c.aluop = ALU_SLT;
                  3'b100:         c.aluop = ALU_AND;
                  3'b101:         c.aluop = ALU_OR;
                  3'b110:         c.aluop = ALU_XOR;
                  default:        c.aluop = ALU_LUI;
               endcase
            end
         end
      endcase
   end

   assign ctrl = c;

endmodule

// File: rtl/id_ctrl_stage.sv
// ID-stage control: decode, load-use hazard detection and the ID/EX control register.
// Build option: MULDIV_EN adds the mult/div busy counter and hi/lo interlock.
module id_ctrl_stage
   import ctrl_pkg::*;
#(
   parameter int REG_AW  = 5,
   parameter int MUL_LAT = 4,
   parameter int DIV_LAT = 32,
   parameter int CNT_W   = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [5:0]        id_opcode,
   input  logic [5:0]        id_funct,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              ex_flush,
   input  logic              ex_stall,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [REG_AW-1:0] ex_rt,
   output logic              illegal
);

   logic [CTRL_W-1:0] dec_ctrl;
   logic              dec_legal;
   logic              dec_uses_rs;
   logic              dec_uses_rt;
   logic              hazard;
   logic              interlock;
   logic              advance;
   logic              load;

   ctrl_dec u_dec (
      .opcode  (id_opcode),
      .funct   (id_funct),
      .ctrl    (dec_ctrl),
      .legal   (dec_legal),
      .uses_rs (dec_uses_rs),
      .uses_rt (dec_uses_rt)
   );

   assign hazard = ex_valid && ex_ctrl[CTRL_MEMREAD] && id_valid && (ex_rt != '0) &&
                   ((dec_uses_rs && ex_rt == id_rs) || (dec_uses_rt && ex_rt == id_rt));

   assign advance  = !ex_flush && !ex_stall && !hazard && !interlock;
   assign load     = id_valid && dec_legal;
   // A flush drops the ID instruction, so it is consumed even under stall or hazard.
   assign id_ready = ex_flush || advance;

`ifdef MULDIV_EN
   logic [CNT_W-1:0] busy_cnt;

   assign interlock = id_valid && (busy_cnt != '0) && (id_opcode == OP_RTYPE) && is_hilo_fn(id_funct);

   // Counter only loads on real acceptance; a later flush leaves it running.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_cnt <= '0;
      end else if (advance && load && dec_ctrl[CTRL_MULDIV]) begin
         // funct[1] separates div/divu (1a/1b) from mult/multu (18/19).
         busy_cnt <= id_funct[1] ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
      end else if (busy_cnt != '0) begin
         busy_cnt <= busy_cnt - 1'b1;
      end
   end
`else
   localparam int unused_muldiv_cfg = MUL_LAT + DIV_LAT + CNT_W;
   assign interlock = 1'b0;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
         ex_rt    <= '0;
         illegal  <= 1'b0;
      end else if (ex_flush) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
         ex_rt    <= '0;
         illegal  <= 1'b0;
      end else if (ex_stall) begin
         illegal  <= 1'b0;
      end else if (hazard || interlock) begin
         ex_valid <= 1'b0;
         ex_ctrl  <= '0;
         ex_rt    <= '0;
         illegal  <= 1'b0;
      end else begin
         ex_valid <= load;
         ex_ctrl  <= load ? dec_ctrl : '0;
         ex_rt    <= id_rt;
         illegal  <= id_valid && !dec_legal;
      end
   end

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Self-checking bench for id_ctrl_stage: decode table plus hazard/stall/flush/interlock sequences.
// Build option: MULDIV_EN switches the mult/div checks from illegal-decode to interlock timing.
module tb_id_ctrl_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic        id_ready;
   logic [5:0]  id_opcode;
   logic [5:0]  id_funct;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        ex_flush;
   logic        ex_stall;
   logic        ex_valid;
   logic [15:0] ex_ctrl;
   logic [4:0]  ex_rt;
   logic        illegal;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected bundles, written out bit by bit:
   // signext_aluop_{alusrc memread memwrite memtoreg}_{regwrite regdst branch branchne}_{jump jumpr link muldiv}
   localparam logic [15:0] C_ADDI  = 16'b1_000_1000_1000_0000;
   localparam logic [15:0] C_ADDIU = 16'b1_000_1000_1000_0000;
   localparam logic [15:0] C_SLTI  = 16'b1_111_1000_1000_0000;
   localparam logic [15:0] C_ANDI  = 16'b0_011_1000_1000_0000;
   localparam logic [15:0] C_ORI   = 16'b0_100_1000_1000_0000;
   localparam logic [15:0] C_XORI  = 16'b0_101_1000_1000_0000;
   localparam logic [15:0] C_LUI   = 16'b0_110_1000_1000_0000;
   localparam logic [15:0] C_LW    = 16'b1_000_1101_1000_0000;
   localparam logic [15:0] C_SW    = 16'b1_000_1010_0000_0000;
   localparam logic [15:0] C_BEQ   = 16'b0_001_0000_0010_0000;
   localparam logic [15:0] C_BNE   = 16'b0_001_0000_0011_0000;
   localparam logic [15:0] C_J     = 16'b0_000_0000_0000_1000;
   localparam logic [15:0] C_JAL   = 16'b0_000_0000_1000_1010;
   localparam logic [15:0] C_JR    = 16'b0_000_0000_0000_1100;
   localparam logic [15:0] C_ADD   = 16'b0_010_0000_1100_0000;
   localparam logic [15:0] C_MULT  = 16'b0_010_0000_0000_0001;

   typedef struct {
      string      name;
      logic [5:0] op;
      logic [5:0] fn;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [15:0] c;
      logic       ill;
   } vec_t;

   typedef struct {
      logic        v;
      logic [15:0] c;
      logic [4:0]  rt;
      logic        ill;
   } exp_t;

   vec_t vecs[$];
   exp_t exp_q[$];

   id_ctrl_stage dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .id_valid  (id_valid),
      .id_ready  (id_ready),
      .id_opcode (id_opcode),
      .id_funct  (id_funct),
      .id_rs     (id_rs),
      .id_rt     (id_rt),
      .ex_flush  (ex_flush),
      .ex_stall  (ex_stall),
      .ex_valid  (ex_valid),
      .ex_ctrl   (ex_ctrl),
      .ex_rt     (ex_rt),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One cycle: drive at negedge, check id_ready, queue the expected register state, compare after the edge.
   task automatic step(input string name, input logic v, input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt, input logic fl, input logic st,
                       input logic exp_ready, input logic exp_v, input logic [15:0] exp_c,
                       input logic [4:0] exp_rt, input logic exp_ill);
      exp_t e;
      @(negedge clk);
      id_valid  = v;
      id_opcode = op;
      id_funct  = fn;
      id_rs     = rs;
      id_rt     = rt;
      ex_flush  = fl;
      ex_stall  = st;
      #1;
      check({name, ".id_ready"}, id_ready, exp_ready);
      exp_q.push_back('{v: exp_v, c: exp_c, rt: exp_rt, ill: exp_ill});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check({name, ".ex_valid"}, ex_valid, e.v);
      check({name, ".ex_ctrl"}, ex_ctrl, e.c);
      check({name, ".illegal"}, illegal, e.ill);
      if (e.v) check({name, ".ex_rt"}, ex_rt, e.rt);
   endtask

   task automatic idle(input string name);
      step(name, 1'b0, 6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 5'd0, 1'b0);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; id_valid = 1'b0; id_opcode = '0; id_funct = '0;
      id_rs = '0; id_rt = '0; ex_flush = 1'b0; ex_stall = 1'b0;

      vecs.push_back('{"addi",  6'h08, 6'h00, 5'd1, 5'd2, C_ADDI,  1'b0});
      vecs.push_back('{"andi",  6'h0c, 6'h00, 5'd3, 5'd4, C_ANDI,  1'b0});
      vecs.push_back('{"addiu", 6'h09, 6'h00, 5'd1, 5'd7, C_ADDIU, 1'b0});
      vecs.push_back('{"slti",  6'h0a, 6'h00, 5'd2, 5'd8, C_SLTI,  1'b0});
      vecs.push_back('{"ori",   6'h0d, 6'h00, 5'd4, 5'd9, C_ORI,   1'b0});
      vecs.push_back('{"xori",  6'h0e, 6'h00, 5'd5, 5'd10, C_XORI, 1'b0});
      vecs.push_back('{"lui",   6'h0f, 6'h00, 5'd0, 5'd11, C_LUI,  1'b0});
      vecs.push_back('{"lw",    6'h23, 6'h00, 5'd1, 5'd5, C_LW,    1'b0});
      vecs.push_back('{"sw",    6'h2b, 6'h00, 5'd2, 5'd3, C_SW,    1'b0});
      vecs.push_back('{"beq",   6'h04, 6'h00, 5'd1, 5'd2, C_BEQ,   1'b0});
      vecs.push_back('{"bne",   6'h05, 6'h00, 5'd3, 5'd4, C_BNE,   1'b0});
      vecs.push_back('{"j",     6'h02, 6'h00, 5'd0, 5'd0, C_J,     1'b0});
      vecs.push_back('{"jal",   6'h03, 6'h00, 5'd0, 5'd31, C_JAL,  1'b0});
      vecs.push_back('{"jr",    6'h00, 6'h08, 5'd31, 5'd0, C_JR,   1'b0});
      vecs.push_back('{"add",   6'h00, 6'h20, 5'd1, 5'd2, C_ADD,   1'b0});
      vecs.push_back('{"op3f",  6'h3f, 6'h00, 5'd1, 5'd2, 16'h0,   1'b1});
      vecs.push_back('{"op11",  6'h11, 6'h00, 5'd1, 5'd2, 16'h0,   1'b1});
`ifndef MULDIV_EN
      vecs.push_back('{"mult_off", 6'h00, 6'h18, 5'd1, 5'd2, 16'h0, 1'b1});
      vecs.push_back('{"mflo_off", 6'h00, 6'h12, 5'd0, 5'd0, 16'h0, 1'b1});
`endif

      // Reset state, held in reset.
      #12;
      check("rst.ex_valid", ex_valid, 1'b0);
      check("rst.ex_ctrl", ex_ctrl, 16'h0);
      check("rst.ex_rt", ex_rt, 5'd0);
      check("rst.illegal", illegal, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst.id_ready", id_ready, 1'b1);

      // Decode table: each instruction followed by an idle cycle so the previous load never interferes.
      foreach (vecs[i]) begin
         step(vecs[i].name, 1'b1, vecs[i].op, vecs[i].fn, vecs[i].rs, vecs[i].rt, 1'b0, 1'b0,
              1'b1, ~vecs[i].ill, vecs[i].c, vecs[i].rt, vecs[i].ill);
         idle({vecs[i].name, ".after"});
      end

      // Load-use on rs: one bubble, then the add issues.
      step("lu.lw",     1, 6'h23, 6'h00, 5'd1, 5'd5, 0, 0, 1, 1, C_LW, 5'd5, 0);
      step("lu.bubble", 1, 6'h00, 6'h20, 5'd5, 5'd6, 0, 0, 0, 0, 16'h0, 5'd0, 0);
      step("lu.add",    1, 6'h00, 6'h20, 5'd5, 5'd6, 0, 0, 1, 1, C_ADD, 5'd6, 0);
      // Load to r0 never creates a hazard.
      step("lu0.lw",    1, 6'h23, 6'h00, 5'd1, 5'd0, 0, 0, 1, 1, C_LW, 5'd0, 0);
      step("lu0.add",   1, 6'h00, 6'h20, 5'd0, 5'd6, 0, 0, 1, 1, C_ADD, 5'd6, 0);
      // Hazard through rt for sw, none for addi whose rt is a destination.
      step("lut.lw",    1, 6'h23, 6'h00, 5'd1, 5'd7, 0, 0, 1, 1, C_LW, 5'd7, 0);
      step("lut.sw_b",  1, 6'h2b, 6'h00, 5'd2, 5'd7, 0, 0, 0, 0, 16'h0, 5'd0, 0);
      step("lut.sw",    1, 6'h2b, 6'h00, 5'd2, 5'd7, 0, 0, 1, 1, C_SW, 5'd7, 0);
      step("lut.lw2",   1, 6'h23, 6'h00, 5'd1, 5'd7, 0, 0, 1, 1, C_LW, 5'd7, 0);
      step("lut.addi",  1, 6'h08, 6'h00, 5'd2, 5'd7, 0, 0, 1, 1, C_ADDI, 5'd7, 0);
      idle("lut.idle");

      // Stall holds beq for three cycles; an illegal opcode waiting in ID must not pulse.
      step("st.beq",    1, 6'h04, 6'h00, 5'd1, 5'd2, 0, 0, 1, 1, C_BEQ, 5'd2, 0);
      for (int k = 0; k < 3; k++)
         step("st.hold", 1, 6'h3f, 6'h00, 5'd1, 5'd2, 0, 1, 0, 1, C_BEQ, 5'd2, 0);
      step("st.flush",  1, 6'h00, 6'h20, 5'd1, 5'd2, 1, 1, 1, 0, 16'h0, 5'd0, 0);
      idle("st.idle");

      // Hazard and flush together: flush wins, and the next instruction is not delayed.
      step("hf.lw",     1, 6'h23, 6'h00, 5'd1, 5'd5, 0, 0, 1, 1, C_LW, 5'd5, 0);
      step("hf.flush",  1, 6'h00, 6'h20, 5'd5, 5'd6, 1, 0, 1, 0, 16'h0, 5'd0, 0);
      step("hf.ori",    1, 6'h0d, 6'h00, 5'd5, 5'd9, 0, 0, 1, 1, C_ORI, 5'd9, 0);
      idle("hf.idle");

`ifdef MULDIV_EN
      step("md.mult",   1, 6'h00, 6'h18, 5'd1, 5'd2, 0, 0, 1, 1, C_MULT, 5'd2, 0);
      for (int k = 0; k < 4; k++)
         step("md.mflo_wait", 1, 6'h00, 6'h12, 5'd0, 5'd0, 0, 0, 0, 0, 16'h0, 5'd0, 0);
      step("md.mflo",   1, 6'h00, 6'h12, 5'd0, 5'd3, 0, 0, 1, 1, C_ADD, 5'd3, 0);
      step("md.div",    1, 6'h00, 6'h1a, 5'd1, 5'd2, 0, 0, 1, 1, C_MULT, 5'd2, 0);
      for (int k = 0; k < 32; k++)
         step("md.mfhi_wait", 1, 6'h00, 6'h10, 5'd0, 5'd0, 0, 0, 0, 0, 16'h0, 5'd0, 0);
      step("md.mfhi",   1, 6'h00, 6'h10, 5'd0, 5'd4, 0, 0, 1, 1, C_ADD, 5'd4, 0);
      idle("md.idle");
`endif

      // Reset in the middle of operation clears the register immediately.
      step("mr.addi",   1, 6'h08, 6'h00, 5'd1, 5'd2, 0, 0, 1, 1, C_ADDI, 5'd2, 0);
      @(negedge clk);
      id_valid = 1'b1;
      #1;
      rst_n = 1'b0;
      #1;
      check("mr.ex_valid", ex_valid, 1'b0);
      check("mr.ex_ctrl", ex_ctrl, 16'h0);
      check("mr.ex_rt", ex_rt, 5'd0);
      @(negedge clk);
      rst_n = 1'b1;
      id_valid = 1'b0;
      #1;
      check("mr.id_ready", id_ready, 1'b1);
      idle("mr.idle");

      check("sb.empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
